serial_bus_master: RTL and testbench
====================================

# serial_bus_master

- Initiator end of the team's single-wire serial memory bus.
- Accepts parallel read/write requests on a valid/ready handshake and serializes them MSB-first onto the bus: start cycle, ADN address bits, turnaround, then N write-data bits or a wait for read data.
- On reads, deserializes the responder's N-bit reply and returns it with a one-cycle response pulse.
- Sits between a local requester (CPU or test sequencer) and one bus responder.

## Interface
- ADN, 12, address length in bits
- N, 8, data width in bits
- TIMEOUT, 64, max cycles to wait for read data after turnaround before flagging error
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request this cycle
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADN  request address
- req_wdata  in  N  write data
- resp_valid  out  1  one-cycle pulse at request completion
- resp_rdata  out  N  read data, valid with resp_valid on reads
- resp_err  out  1  read timeout, valid with resp_valid
- busValid  out  1  frame-active strobe to responder
- busWren  out  1  write enable to responder, held constant through a frame
- busAddress  out  1  serial address bit
- busDataOut  out  1  serial write-data bit
- busReady  in  1  responder idle/ready
- busValidIn  in  1  responder read-data strobe
- busDataIn  in  1  serial read-data bit

## Operation
- **States:** IDLE, START, ADDR, TURN, WDATA, RWAIT, RDATA, DONE.
- **IDLE**
  - req_ready = busReady.
  - On req_valid && req_ready: latch req_wr, req_addr, req_wdata into shadow registers and go to START.
- **START:** busValid=1, busWren=latched wr, busAddress=addr[ADN-1]. The responder ignores this bit. Go to ADDR.
- **ADDR**
  - ADN cycles, busValid=1; busAddress presents addr bit ADN-1 down to 0, one per cycle.
  - 5-bit address counter, 0..ADN-1.
  - After the bit-0 cycle, go to TURN.
- **TURN:** one cycle, busValid=1, busAddress=0. Go to WDATA if wr, else RWAIT.
- **WDATA**
  - N cycles, busValid=1; busDataOut presents wdata bit N-1 down to 0.
  - After the bit-0 cycle, go to DONE with resp_err=0.
- **RWAIT**
  - busValid=0, busWren held 0. Timeout counter counts up from 0.
  - First cycle with busValidIn=1 is the header; its busDataIn is discarded. Go to RDATA.
  - If the counter reaches TIMEOUT first: go to DONE with resp_err=1 and resp_rdata=0.
- **RDATA**
  - Each cycle with busValidIn=1 shifts busDataIn into the read shift register LSB-side (MSB arrives first).
  - After N bits, go to DONE.
  - A busValidIn=0 cycle inside RDATA stalls the capture; no bit is taken and no error is raised.
- **DONE:** resp_valid=1 for exactly this cycle; resp_rdata/resp_err updated. Return to IDLE.
- **Output defaults:** busAddress and busDataOut drive 0 whenever not carrying a bit.
- **Request handling:** req_* is ignored outside IDLE. Only one request is outstanding at a time.

## Timing
- **Reset values:** req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busValid=0, busWren=0, busAddress=0, busDataOut=0, state=IDLE, all counters 0.
- **Reset mid-frame:** every output returns to its reset value on the next edge and the frame is abandoned. The system must also reset the responder.
- **Outputs are registered.** Bus outputs change only on clk edges.
- **Request acceptance:** the accepting edge is cycle 0; START drives the bus in cycle 1.
- **Write latency:** START 1 + ADN + TURN 1 + N = 22 cycles with defaults. resp_valid asserts in cycle 23 after acceptance.
- **Read latency:** 1 + ADN + 1 + (RWAIT cycles up to and including header) + N data cycles + 1.
- **Ready after completion:** req_ready can reassert at the earliest the cycle after DONE, gated by busReady. Back-to-back requests have no overlap.
- **busValidIn outside RWAIT/RDATA:** ignored.
- **Timeout boundary:** the header arriving in the same cycle the counter hits TIMEOUT counts as success; the header takes precedence.

## Test plan
- **Reset:** hold rst 3 cycles mid-write frame -> all outputs 0 the next cycle, state IDLE, req_ready follows busReady afterwards.
- **Write:** addr=0xA5C, wdata=0x3B -> bus shows start, bits 1010_0101_1100, turnaround, 0011_1011 with busValid=1, busWren=1; resp_valid pulse 23 cycles after acceptance, resp_err=0.
- **Read:** addr=0x001; responder model returns header then 0xC6 after 2 idle cycles -> busWren=0 throughout; resp_rdata=0xC6, resp_err=0.
- **Read stall:** responder drops busValidIn for 3 cycles after bit 4 of 0x5A -> resp_rdata=0x5A, no error.
- **Timeout:** read with no busValidIn -> resp_valid exactly TIMEOUT cycles after TURN, resp_err=1, resp_rdata=0; req_ready reasserts after.
- **Handshake:** req_valid held high with busReady=0 -> no frame starts; raise busReady -> accepted the same cycle, new req_addr changes during the frame have no effect.

Source files
------------

// File: rtl/serial_bus_master.sv
// Initiator side of the single-wire serial memory bus: takes one parallel request
// at a time, shifts it out MSB-first, and collects the responder's read reply.
module serial_bus_master #(
  parameter int ADN     = 12,
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_wr,
  input  logic [ADN-1:0] req_addr,
  input  logic [N-1:0]   req_wdata,
  output logic           resp_valid,
  output logic [N-1:0]   resp_rdata,
  output logic           resp_err,
  output logic           busValid,
  output logic           busWren,
  output logic           busAddress,
  output logic           busDataOut,
  input  logic           busReady,
  input  logic           busValidIn,
  input  logic           busDataIn
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, TURN, WDATA, RWAIT, RDATA, DONE
  } state_t;

  state_t         state, stateNext;
  logic           wrLatch, wrNext;
  logic [ADN-1:0] addrShift, addrShiftNext;
  logic [N-1:0]   wdataShift, wdataShiftNext;
  logic [N-1:0]   rdataShift, rdataShiftNext;
  logic [4:0]     addrCount, addrCountNext;
  logic [BW-1:0]  bitCount, bitCountNext;
  logic [TW-1:0]  waitCount, waitCountNext;
  logic           accept;
  logic           frameDrive;
  logic           busValidNext, busWrenNext, busAddressNext, busDataOutNext;
  logic           respValidNext, respErrNext;
  logic [N-1:0]   respRdataNext;

  assign req_ready = (state == IDLE) && busReady && !rst;
  assign accept    = req_valid && req_ready;

  // Bus outputs are computed from the next state so they come straight out of flops.
  always_comb begin
    stateNext      = state;
    wrNext         = wrLatch;
    addrShiftNext  = addrShift;
    wdataShiftNext = wdataShift;
    rdataShiftNext = rdataShift;
    addrCountNext  = addrCount;
    bitCountNext   = bitCount;
    waitCountNext  = waitCount;
    respErrNext    = resp_err;
    respRdataNext  = resp_rdata;

    case (state)
      IDLE: begin
        if (accept) begin
          stateNext      = START;
          wrNext         = req_wr;
          addrShiftNext  = req_addr;
          wdataShiftNext = req_wdata;
          rdataShiftNext = '0;
          addrCountNext  = '0;
          bitCountNext   = '0;
          waitCountNext  = '0;
        end
      end
      START: stateNext = ADDR;
      ADDR: begin
        if (addrCount == 5'(ADN - 1)) begin
          stateNext = TURN;
        end else begin
          addrCountNext = addrCount + 5'd1;
          addrShiftNext = addrShift << 1;
        end
      end
      TURN: begin
        stateNext     = wrLatch ? WDATA : RWAIT;
        waitCountNext = TW'(1);
      end
      WDATA: begin
        if (bitCount == BW'(N - 1)) begin
          stateNext     = DONE;
          respErrNext   = 1'b0;
          respRdataNext = '0;
        end else begin
          bitCountNext   = bitCount + BW'(1);
          wdataShiftNext = wdataShift << 1;
        end
      end
      // waitCount holds the number of cycles since the turnaround cycle
      RWAIT: begin
        if (busValidIn) begin
          stateNext = RDATA;
        end else if (waitCount == TW'(TIMEOUT - 1)) begin
          stateNext     = DONE;
          respErrNext   = 1'b1;
          respRdataNext = '0;
        end else begin
          waitCountNext = waitCount + TW'(1);
        end
      end
      RDATA: begin
        if (busValidIn) begin
          rdataShiftNext = {rdataShift[N-2:0], busDataIn};
          if (bitCount == BW'(N - 1)) begin
            stateNext     = DONE;
            respErrNext   = 1'b0;
            respRdataNext = rdataShiftNext;
          end else begin
            bitCountNext = bitCount + BW'(1);
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    frameDrive     = stateNext inside {START, ADDR, TURN, WDATA};
    busValidNext   = frameDrive;
    busWrenNext    = frameDrive && wrNext;
    busAddressNext = ((stateNext == START) || (stateNext == ADDR)) && addrShiftNext[ADN-1];
    busDataOutNext = (stateNext == WDATA) && wdataShiftNext[N-1];
    respValidNext  = (stateNext == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wrLatch    <= 1'b0;
      addrShift  <= '0;
      wdataShift <= '0;
      rdataShift <= '0;
      addrCount  <= '0;
      bitCount   <= '0;
      waitCount  <= '0;
      busValid   <= 1'b0;
      busWren    <= 1'b0;
      busAddress <= 1'b0;
      busDataOut <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= stateNext;
      wrLatch    <= wrNext;
      addrShift  <= addrShiftNext;
      wdataShift <= wdataShiftNext;
      rdataShift <= rdataShiftNext;
      addrCount  <= addrCountNext;
      bitCount   <= bitCountNext;
      waitCount  <= waitCountNext;
      busValid   <= busValidNext;
      busWren    <= busWrenNext;
      busAddress <= busAddressNext;
      busDataOut <= busDataOutNext;
      resp_valid <= respValidNext;
      resp_rdata <= respRdataNext;
      resp_err   <= respErrNext;
    end
  end

endmodule

// File: tb/tb_serial_bus_master.sv
// Scoreboard bench for serial_bus_master: a stimulus process plays requester and
// responder, a negedge monitor checks the serial frame and every response.
module tb_serial_bus_master;

  localparam int ADN     = 12;
  localparam int N       = 8;
  localparam int TIMEOUT = 64;
  localparam int TURN_K  = 1 + ADN + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_wr = 1'b0;
  logic [ADN-1:0] req_addr = '0;
  logic [N-1:0]   req_wdata = '0;
  logic           resp_valid;
  logic [N-1:0]   resp_rdata;
  logic           resp_err;
  logic           busValid, busWren, busAddress, busDataOut;
  logic           busReady = 1'b1;
  logic           busValidIn = 1'b0;
  logic           busDataIn = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit checkEnable = 1'b0;

  typedef struct {
    logic           wr;
    logic [ADN-1:0] addr;
    logic [N-1:0]   wdata;
    logic [N-1:0]   rdata;
    logic           err;
    int             latency;
    int             acceptCyc;
  } exp_t;

  exp_t expQ[$];

  serial_bus_master #(.ADN(ADN), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busValid(busValid), .busWren(busWren), .busAddress(busAddress), .busDataOut(busDataOut),
    .busReady(busReady), .busValidIn(busValidIn), .busDataIn(busDataIn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Expected {req_ready, busValid, busWren, busAddress, busDataOut} in cycle k of a frame.
  function automatic void busExpect(input exp_t e, input int k, input logic rdy,
                                    output logic [4:0] v, output logic [4:0] m);
    m = 5'b11111;
    if (k <= 0)                           v = {rdy, 4'b0000};
    else if (k <= ADN + 1)                v = {1'b0, 1'b1, e.wr, e.addr[ADN - ((k == 1) ? 1 : (k - 1))], 1'b0};
    else if (k == TURN_K)                 v = {1'b0, 1'b1, e.wr, 1'b0, 1'b0};
    else if (e.wr && k <= TURN_K + N)     v = {1'b0, 1'b1, 1'b1, 1'b0, e.wdata[TURN_K + N - k]};
    else begin
      v = 5'b00000;
      if (!e.wr && k < e.latency) m = 5'b10111;
    end
  endfunction

  exp_t       monItem;
  logic [4:0] monExp, monMask;

  always @(negedge clk) begin
    if (checkEnable) begin
      if (expQ.size() == 0) begin
        monExp  = {busReady, 4'b0000};
        monMask = 5'b11111;
      end else begin
        busExpect(expQ[0], cyc - expQ[0].acceptCyc, busReady, monExp, monMask);
      end
      checkOutput("bus", {27'd0, {req_ready, busValid, busWren, busAddress, busDataOut} & monMask},
                  {27'd0, monExp & monMask});
      if (resp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("resp_unexpected", 32'd1, 32'd0);
        end else begin
          monItem = expQ.pop_front();
          checkOutput("latency", cyc - monItem.acceptCyc, monItem.latency);
          checkOutput("resp_err", {31'd0, resp_err}, {31'd0, monItem.err});
          if (!monItem.wr) checkOutput("resp_rdata", {24'd0, resp_rdata}, {24'd0, monItem.rdata});
        end
      end
    end
  end

  // hdrDelay: idle RWAIT cycles before the header, negative for no header at all.
  task automatic applyStimulus(input logic wr, input logic [ADN-1:0] addr, input logic [N-1:0] wdata,
                               input logic [N-1:0] rdata, input int hdrDelay, input int stallAfter,
                               input int stallLen, input int readyDelay);
    exp_t       e;
    bit         ok;
    int         lastK, stall;
    logic [1:0] plan[$];
    @(posedge clk); #1;
    req_wr = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    if (readyDelay > 0) begin
      busReady = 1'b0;
      repeat (readyDelay) begin @(posedge clk); #1; end
      busReady = 1'b1;
    end
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checkOutput("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    stall = (stallAfter >= 0 && stallAfter < N - 1) ? stallLen : 0;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.acceptCyc = cyc;
    if (wr) begin
      e.err = 1'b0; e.latency = TURN_K + N + 1;
    end else if (hdrDelay >= 0 && hdrDelay + 1 < TIMEOUT) begin
      e.err = 1'b0; e.latency = TURN_K + (hdrDelay + 1) + N + stall + 1;
    end else begin
      e.err = 1'b1; e.rdata = '0; e.latency = TURN_K + TIMEOUT;
    end
    expQ.push_back(e);

    for (int k = 1; k <= TURN_K; k++) plan.push_back({1'($urandom), 1'($urandom)});
    if (wr) begin
      for (int k = 0; k <= N; k++) plan.push_back({1'($urandom), 1'($urandom)});
    end else if (hdrDelay >= 0) begin
      repeat (hdrDelay) plan.push_back({1'b0, 1'($urandom)});
      plan.push_back({1'b1, 1'($urandom)});
      for (int i = 0; i < N; i++) begin
        plan.push_back({1'b1, rdata[N-1-i]});
        if (i == stallAfter) repeat (stall) plan.push_back({1'b0, 1'($urandom)});
      end
    end
    lastK = ((e.latency > plan.size()) ? e.latency : plan.size()) + 1;

    @(posedge clk); #1;
    for (int k = 1; k <= lastK; k++) begin
      {busValidIn, busDataIn} = (k <= plan.size()) ? plan[k-1] : 2'b00;
      req_valid = (k <= 4);
      if (k <= 4) begin
        req_addr = ADN'($urandom); req_wdata = N'($urandom); req_wr = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    busValidIn = 1'b0; busDataIn = 1'b0; req_valid = 1'b0;
  endtask

  task automatic resetMidFrame();
    bit ok;
    checkEnable = 1'b0;
    @(posedge clk); #1;
    req_wr = 1'b1; req_addr = 12'h3C5; req_wdata = 8'h99; req_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    checkOutput("reset_test_accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    checkOutput("frame_active_before_reset", {31'd0, busValid}, 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checkOutput("reset_outputs", {17'd0, req_ready, resp_valid, resp_rdata, resp_err,
                  busValid, busWren, busAddress, busDataOut}, 32'd0);
    end
    rst = 1'b0; #1;
    checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);
    busReady = 1'b0; #1;
    checkOutput("ready_follows_busReady", {31'd0, req_ready}, 32'd0);
    busReady = 1'b1;
    expQ.delete();
    checkEnable = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wr, d, sa, sl, rd;
    repeat (2) @(posedge clk);
    @(posedge clk); @(negedge clk);
    checkOutput("initial_reset_outputs", {17'd0, req_ready, resp_valid, resp_rdata, resp_err,
                busValid, busWren, busAddress, busDataOut}, 32'd0);
    rst = 1'b0;
    checkEnable = 1'b1;

    applyStimulus(1'b1, 12'hA5C, 8'h3B, 8'h00, -1, -1, 0, 0);
    applyStimulus(1'b0, 12'h001, 8'h00, 8'hC6, 2, -1, 0, 0);
    applyStimulus(1'b0, 12'h2B7, 8'h00, 8'h5A, 1, 4, 3, 0);
    applyStimulus(1'b0, 12'h7FF, 8'h00, 8'hFF, -1, -1, 0, 0);
    applyStimulus(1'b0, 12'h800, 8'h00, 8'h81, TIMEOUT - 2, -1, 0, 0);
    applyStimulus(1'b0, 12'h0F0, 8'h00, 8'h42, TIMEOUT - 1, -1, 0, 0);
    applyStimulus(1'b1, 12'hFFF, 8'hA5, 8'h00, -1, -1, 0, 5);
    resetMidFrame();
    applyStimulus(1'b1, 12'h123, 8'h80, 8'h00, -1, -1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      wr = $urandom_range(0, 1);
      d  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 8);
      sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 2) : -1;
      sl = $urandom_range(1, 4);
      rd = $urandom_range(0, 3);
      applyStimulus(1'(wr), ADN'($urandom), N'($urandom), N'($urandom), d, sa, sl, rd);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    checkEnable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
